reg_file_sb: RTL and testbench

Parametrised integer register file with N read ports, one write port, same-cycle write-to-read bypass and a per-register busy scoreboard. Sits between decode and writeback in the pipeline. Decode reads operands and marks destination registers busy at issue. Writeback updates the array and clears busy, so hazard detection and operand forwarding for writeback live in one block.

---
 rtl/reg_file_sb.sv | 114 +++++++++++
 tb/tb_reg_file_sb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb
// Integer register file with NREAD combinational read ports, one write
// port, same-cycle write-to-read bypass and a per-register busy scoreboard.
// Decode reads operands and marks destinations busy at issue; writeback
// updates the array and clears busy.
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst_n     asynchronous active-low reset (clears array and scoreboard)
//   raddr     NREAD read addresses, port i at [i*AW +: AW]
//   rdata     NREAD read data (combinational), port i at [i*XLEN +: XLEN]
//   rbusy     per-port "operand still pending" flag
//   wr_en     writeback valid
//   waddr     writeback address
//   wdata     writeback data
//   iss_en    issue valid, marks iss_rd busy
//   iss_rd    destination register of the issued instruction
//   flush     clears every busy bit, array untouched
//   busy_vec  current scoreboard, bit r = register r busy
module reg_file_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREAD*AW-1:0]   raddr,
    output logic [NREAD*XLEN-1:0] rdata,
    output logic [NREAD-1:0]      rbusy,
    input  logic                  wr_en,
    input  logic [AW-1:0]         waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_rd,
    input  logic                  flush,
    output logic [NREGS-1:0]      busy_vec
);

    // One extra bit so NREGS itself is representable for the range check.
    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    // True for addresses that name a real, writable register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREGS_W) && !(ZERO_REG && (a == '0));
    endfunction

    logic [XLEN-1:0]  regs_reg [NREGS];
    logic [NREGS-1:0] busy_reg;
    logic [NREGS-1:0] busy_next;
    logic             wr_ok;
    logic             iss_ok;

    assign wr_ok  = wr_en && addr_ok(waddr);
    assign iss_ok = iss_en && addr_ok(iss_rd);

    // Register array: flops rather than block RAM, since reset must clear it
    // and several ports read it combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_reg[r] <= '0;
            end
        end else if (wr_ok) begin
            regs_reg[waddr] <= wdata;
        end
    end

    // Scoreboard: flush beats issue, issue beats writeback so that a new
    // producer issued in the same cycle as the old one retires stays pending.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_busy
            assign busy_next[gi] = flush                               ? 1'b0 :
                                   (iss_ok && (iss_rd == AW'(gi)))     ? 1'b1 :
                                   (wr_ok && (waddr == AW'(gi)))       ? 1'b0 :
                                                                         busy_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy_vec = busy_reg;

    // Read ports. The bypass is gated by rst_n so that rdata reads 0 for
    // every address while reset is held, even with wr_en asserted.
    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_read
            logic [AW-1:0] ra;
            logic [AW-1:0] ra_safe;
            logic          ok;
            logic          hit;

            assign ra      = raddr[gi*AW +: AW];
            assign ok      = addr_ok(ra);
            // Clamp so an out-of-range address never indexes past the array.
            assign ra_safe = ok ? ra : '0;
            assign hit     = rst_n && wr_en && (waddr == ra);

            assign rdata[gi*XLEN +: XLEN] = !ok ? '0 :
                                            hit ? wdata :
                                                  regs_reg[ra_safe];
            assign rbusy[gi] = ok && busy_reg[ra_safe] && !hit;
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb. Three instances: default (ZERO_REG=1),
// ZERO_REG=0 sharing the same stimulus, and NREGS=20/NREAD=3/XLEN=64.
// Expected values are pushed to a scoreboard queue as stimulus is driven and
// popped when the DUT output is sampled.
module tb_reg_file_sb;

    logic        clk;
    logic        rst_n;

    // Shared stimulus for instances a (ZERO_REG=1) and b (ZERO_REG=0)
    logic [9:0]  raddr;
    logic        wr_en;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic        flush;
    logic [63:0] a_rdata, b_rdata;
    logic [1:0]  a_rbusy, b_rbusy;
    logic [31:0] a_busy, b_busy;

    // Instance c: NREGS=20, NREAD=3, XLEN=64
    logic [14:0]  c_raddr;
    logic         c_wr_en;
    logic [4:0]   c_waddr;
    logic [63:0]  c_wdata;
    logic         c_iss_en;
    logic [4:0]   c_iss_rd;
    logic         c_flush;
    logic [191:0] c_rdata;
    logic [2:0]   c_rbusy;
    logic [19:0]  c_busy;

    reg_file_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(a_rdata), .rbusy(a_rbusy),
        .wr_en(wr_en), .waddr(waddr), .wdata(wdata), .iss_en(iss_en),
        .iss_rd(iss_rd), .flush(flush), .busy_vec(a_busy)
    );

    reg_file_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(b_rdata), .rbusy(b_rbusy),
        .wr_en(wr_en), .waddr(waddr), .wdata(wdata), .iss_en(iss_en),
        .iss_rd(iss_rd), .flush(flush), .busy_vec(b_busy)
    );

    reg_file_sb #(.XLEN(64), .NREGS(20), .NREAD(3), .ZERO_REG(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .raddr(c_raddr), .rdata(c_rdata), .rbusy(c_rbusy),
        .wr_en(c_wr_en), .waddr(c_waddr), .wdata(c_wdata), .iss_en(c_iss_en),
        .iss_rd(c_iss_rd), .flush(c_flush), .busy_vec(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    string       tag_q[$];
    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic push_exp(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic chk(input logic [63:0] obs);
        string       t;
        logic [63:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty observed=%h expected=<queued value>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) begin
                n_pass++;
                $display("ok   %-16s observed=%h expected=%h", t, obs, e);
            end else begin
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        raddr  = '0; wr_en = 1'b0; waddr = '0; wdata = '0;
        iss_en = 1'b0; iss_rd = '0; flush = 1'b0;
        c_raddr = '0; c_wr_en = 1'b0; c_waddr = '0; c_wdata = '0;
        c_iss_en = 1'b0; c_iss_rd = '0; c_flush = 1'b0;

        // Reset state
        #2;
        push_exp("rst_busy", 64'h0);      chk(64'(a_busy));
        push_exp("rst_rbusy", 64'h0);     chk(64'(a_rbusy));
        push_exp("rst_c_busy", 64'h0);    chk(64'(c_busy));
        rst_n = 1'b1;

        // Load r5, issue r6, then reset between edges
        wr_en = 1'b1; waddr = 5'd5; wdata = 32'h1234;
        iss_en = 1'b1; iss_rd = 5'd6; raddr = {5'd0, 5'd5};
        step();
        wr_en = 1'b0; iss_en = 1'b0;
        #1;
        push_exp("load_r5", 64'h1234);    chk(64'(a_rdata[31:0]));
        push_exp("issue_r6", 64'h40);     chk(64'(a_busy));
        rst_n = 1'b0;
        #1;
        push_exp("rst_r5", 64'h0);        chk(64'(a_rdata[31:0]));
        push_exp("rst_busy_mid", 64'h0);  chk(64'(a_busy));
        // Writes, issues and bypass are ignored while reset is held
        wr_en = 1'b1; waddr = 5'd5; wdata = 32'h5555; iss_en = 1'b1; iss_rd = 5'd2;
        #1;
        push_exp("rst_no_bypass", 64'h0); chk(64'(a_rdata[31:0]));
        step();
        push_exp("rst_no_write", 64'h0);  chk(64'(a_rdata[31:0]));
        push_exp("rst_no_issue", 64'h0);  chk(64'(a_busy));
        wr_en = 1'b0; iss_en = 1'b0;
        rst_n = 1'b1;

        // Bypass on both ports, then array read after the edge
        wr_en = 1'b1; waddr = 5'd7; wdata = 32'hDEADBEEF; raddr = {5'd7, 5'd7};
        #1;
        push_exp("byp_p0", 64'hDEADBEEF); chk(64'(a_rdata[31:0]));
        push_exp("byp_p1", 64'hDEADBEEF); chk(64'(a_rdata[63:32]));
        step();
        wr_en = 1'b0;
        #1;
        push_exp("arr_p0", 64'hDEADBEEF); chk(64'(a_rdata[31:0]));
        push_exp("arr_p1", 64'hDEADBEEF); chk(64'(a_rdata[63:32]));
        push_exp("wb_nonbusy", 64'h0);    chk(64'(a_busy));

        // Zero register: a ignores, b behaves as a normal register
        wr_en = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        iss_en = 1'b1; iss_rd = 5'd0; raddr = {5'd0, 5'd0};
        #1;
        push_exp("z1_byp", 64'h0);        chk(64'(a_rdata[31:0]));
        push_exp("z0_byp", 64'hFFFFFFFF); chk(64'(b_rdata[31:0]));
        step();
        wr_en = 1'b0; iss_en = 1'b0;
        #1;
        push_exp("z1_read", 64'h0);       chk(64'(a_rdata[31:0]));
        push_exp("z1_busy", 64'h0);       chk(64'(a_busy));
        push_exp("z0_read", 64'hFFFFFFFF); chk(64'(b_rdata[31:0]));
        push_exp("z0_busy", 64'h1);       chk(64'(b_busy));
        push_exp("z0_rbusy", 64'h3);      chk(64'(b_rbusy));

        // Scoreboard: issue r3 at edge 1, writeback at edge 3
        raddr = {5'd0, 5'd3}; iss_en = 1'b1; iss_rd = 5'd3;
        #1;
        push_exp("sb_same_cyc", 64'h0);   chk(64'(a_rbusy[0]));
        step();
        iss_en = 1'b0;
        #1;
        push_exp("sb_busy3", 64'h8);      chk(64'(a_busy));
        push_exp("sb_rbusy", 64'h1);      chk(64'(a_rbusy[0]));
        step();
        wr_en = 1'b1; waddr = 5'd3; wdata = 32'hA5A50003;
        #1;
        push_exp("sb_wb_rbusy", 64'h0);   chk(64'(a_rbusy[0]));
        push_exp("sb_wb_data", 64'hA5A50003); chk(64'(a_rdata[31:0]));
        push_exp("sb_wb_hold", 64'h8);    chk(64'(a_busy));
        step();
        wr_en = 1'b0;
        #1;
        push_exp("sb_cleared", 64'h0);    chk(64'(a_busy));
        push_exp("sb_arr", 64'hA5A50003); chk(64'(a_rdata[31:0]));

        // Issue and writeback to r9 on the same edge
        raddr = {5'd9, 5'd0};
        iss_en = 1'b1; iss_rd = 5'd9; wr_en = 1'b1; waddr = 5'd9; wdata = 32'h99;
        step();
        iss_en = 1'b0; wr_en = 1'b0;
        #1;
        push_exp("coll_busy", 64'h200);   chk(64'(a_busy));
        push_exp("coll_data", 64'h99);    chk(64'(a_rdata[63:32]));
        push_exp("coll_rbusy", 64'h1);    chk(64'(a_rbusy[1]));

        // Flush wins over a concurrent issue
        flush = 1'b1; iss_en = 1'b1; iss_rd = 5'd4;
        step();
        flush = 1'b0; iss_en = 1'b0;
        #1;
        push_exp("flush_a", 64'h0);       chk(64'(a_busy));
        push_exp("flush_b", 64'h0);       chk(64'(b_busy));
        push_exp("flush_data", 64'h99);   chk(64'(a_rdata[63:32]));

        // Wide configuration: r19 on all ports, out-of-range address 25
        c_wr_en = 1'b1; c_waddr = 5'd19; c_wdata = 64'h0123456789ABCDEF;
        c_iss_en = 1'b1; c_iss_rd = 5'd19;
        step();
        c_wr_en = 1'b0; c_iss_en = 1'b0;
        c_raddr = {5'd19, 5'd19, 5'd19};
        #1;
        push_exp("c_p0_r19", 64'h0123456789ABCDEF); chk(c_rdata[63:0]);
        push_exp("c_p1_r19", 64'h0123456789ABCDEF); chk(c_rdata[127:64]);
        push_exp("c_p2_r19", 64'h0123456789ABCDEF); chk(c_rdata[191:128]);
        push_exp("c_rbusy19", 64'h7);     chk(64'(c_rbusy));
        push_exp("c_busy19", 64'h80000);  chk(64'(c_busy));
        c_wr_en = 1'b1; c_waddr = 5'd25; c_wdata = 64'hFFFFFFFFFFFFFFFF;
        c_iss_en = 1'b1; c_iss_rd = 5'd25;
        c_raddr = {5'd19, 5'd19, 5'd25};
        #1;
        push_exp("c_oor_byp", 64'h0);     chk(c_rdata[63:0]);
        push_exp("c_oor_rbusy", 64'h6);   chk(64'(c_rbusy));
        step();
        c_wr_en = 1'b0; c_iss_en = 1'b0;
        #1;
        push_exp("c_oor_read", 64'h0);    chk(c_rdata[63:0]);
        push_exp("c_oor_busy", 64'h80000); chk(64'(c_busy));
        push_exp("c_r19_keep", 64'h0123456789ABCDEF); chk(c_rdata[191:128]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
